// File: rtl/out_port_fifo.sv
// Output port FIFO: buffers words pushed by the core for a downstream consumer.
// Registered head output, sticky overflow flag, optional hold of the last popped word.
module out_port_fifo #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 4,
   parameter int HOLD_LAST = 1,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_outr,
   input  logic [WIDTH-1:0] ra,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             ovf,
   input  logic             clr_ovf
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             push, pop, drop;

   // Handshake decode and next-state for pointers, count, flag and held word
   always_comb begin
      pop      = (count_q != '0) && out_ready;
      push     = ld_outr && ((count_q != CW'(DEPTH)) || pop);
      drop     = ld_outr && (count_q == CW'(DEPTH)) && !pop;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      last_d   = last_q;
      ovf_d    = ovf_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         last_d   = mem_q[rd_ptr_q];
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A same-edge overflow beats the clear so no overflow is ever lost
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // Control state register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         last_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         last_q   <= last_d;
      end
   end

   // Storage array; never reset since empty-state output never reads it
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= ra;
      end
   end

   // Outputs come from registered state only
   always_comb begin
      out_valid = (count_q != '0);
      full      = (count_q == CW'(DEPTH));
      count     = count_q;
      ovf       = ovf_q;
      if (count_q != '0) begin
         out = mem_q[rd_ptr_q];
      end else if (HOLD_LAST != 0) begin
         out = last_q;
      end else begin
         out = '0;
      end
   end

endmodule

// File: tb/tb_out_port_fifo.sv
// Scoreboard bench for out_port_fifo: directed pushes feed an expected queue,
// a negedge monitor checks every word the consumer accepts.
module tb_out_port_fifo;

   logic        clk;
   logic        rst_n;
   logic        ld_outr;
   logic [15:0] ra;
   logic        out_ready;
   logic        clr_ovf;

   logic [15:0] out1, out0;
   logic        valid1, valid0;
   logic        full1, full0;
   logic [2:0]  count1, count0;
   logic        ovf1, ovf0;

   int checks;
   int failures;
   logic [15:0] sb[$];

   out_port_fifo #(.WIDTH(16), .DEPTH(4), .HOLD_LAST(1)) dut (
      .clk(clk), .rst_n(rst_n), .ld_outr(ld_outr), .ra(ra),
      .out(out1), .out_valid(valid1), .out_ready(out_ready),
      .full(full1), .count(count1), .ovf(ovf1), .clr_ovf(clr_ovf)
   );

   out_port_fifo #(.WIDTH(16), .DEPTH(4), .HOLD_LAST(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .ld_outr(ld_outr), .ra(ra),
      .out(out0), .out_valid(valid0), .out_ready(out_ready),
      .full(full0), .count(count0), .ovf(ovf0), .clr_ovf(clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: the consumer accepts on the next edge whenever valid&&ready
   always @(negedge clk) begin
      if (rst_n && valid1 && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected: got %0h expected none", out1);
         end else begin
            chk("pop_data", {16'h0, out1}, {16'h0, sb.pop_front()});
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input bit kept);
      ld_outr = 1'b1;
      ra      = d;
      if (kept) sb.push_back(d);
      sync();
      ld_outr = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      out_ready = 1'b0;
      chk("drain_done", sb.size(), 0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      ld_outr   = 1'b0;
      ra        = '0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      #3;
      chk("rst_count", count1, 0);
      chk("rst_valid", valid1, 0);
      chk("rst_out", out1, 0);
      chk("rst_full", full1, 0);
      chk("rst_ovf", ovf1, 0);
      #9 rst_n = 1'b1;
      sync();

      // single push, no bypass
      out_ready = 1'b1;
      push(16'h1111, 1'b1);
      out_ready = 1'b0;
      @(negedge clk);
      chk("p1_out", out1, 16'h1111);
      chk("p1_valid", valid1, 1);
      chk("p1_count", count1, 1);
      sync();
      drain();

      // fill, overflow
      push(16'hA001, 1'b1);
      push(16'hA002, 1'b1);
      push(16'hA003, 1'b1);
      push(16'hA004, 1'b1);
      push(16'hA005, 1'b0);
      @(negedge clk);
      chk("ovf_full", full1, 1);
      chk("ovf_count", count1, 4);
      chk("ovf_flag", ovf1, 1);
      chk("ovf_head", out1, 16'hA001);
      sync();

      // clear racing an overflow: set wins
      clr_ovf = 1'b1;
      push(16'hA006, 1'b0);
      clr_ovf = 1'b0;
      @(negedge clk);
      chk("clr_race_ovf", ovf1, 1);
      chk("clr_race_count", count1, 4);
      sync();
      clr_ovf = 1'b1;
      sync();
      clr_ovf = 1'b0;
      @(negedge clk);
      chk("clr_ovf", ovf1, 0);
      sync();

      // push and pop together at full
      out_ready = 1'b1;
      push(16'hB000, 1'b1);
      out_ready = 1'b0;
      @(negedge clk);
      chk("pp_count", count1, 4);
      chk("pp_full", full1, 1);
      chk("pp_ovf", ovf1, 0);
      sync();
      drain();

      // hold-last versus zero when empty
      push(16'h00FF, 1'b1);
      drain();
      @(negedge clk);
      chk("empty_valid", valid1, 0);
      chk("hold_out", out1, 16'h00FF);
      chk("zero_out", out0, 16'h0000);
      chk("empty_count", count1, 0);
      sync();

      // ready while empty does nothing
      out_ready = 1'b1;
      sync();
      sync();
      out_ready = 1'b0;
      @(negedge clk);
      chk("idle_count", count1, 0);
      chk("idle_out", out1, 16'h00FF);
      sync();

      // asynchronous reset with words queued
      push(16'hC001, 1'b1);
      push(16'hC002, 1'b1);
      push(16'hC003, 1'b1);
      @(negedge clk);
      chk("pre_rst_count", count1, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", count1, 0);
      chk("arst_valid", valid1, 0);
      chk("arst_out", out1, 0);
      chk("arst_out0", out0, 0);
      sb.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      sync();
      push(16'h1234, 1'b1);
      @(negedge clk);
      chk("post_rst_out", out1, 16'h1234);
      chk("post_rst_count", count1, 1);
      chk("post_rst_valid", valid1, 1);
      sync();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
